// File: rtl/uart_bus_bridge_pkg.sv
// uart_bus_bridge_pkg
// Shared definitions for the UART-to-bus command bridge:
//   - command byte codes (WRITE / READ / PING)
//   - response byte codes (ACK / PONG / ERR)
//   - parser FSM state encoding
package uart_bus_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_PING  = 8'h03;

  localparam logic [7:0] RSP_ACK   = 8'hAA;
  localparam logic [7:0] RSP_PONG  = 8'h55;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/uart_bus_bridge_txser.sv
// uart_bus_bridge_txser
// Serialises a 1..4 byte response, least-significant byte first, onto a
// valid/ready byte port.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   start_i           load a new response (cnt_i bytes taken from word_i)
//   cnt_i             number of bytes to send, 1..4
//   word_i            response word; must stay stable while bytes are sent
//   tx_data_o         byte currently offered
//   tx_valid_o        tx_data_o is valid
//   tx_ready_i        consumer accepts the byte when valid and ready are high
//   done_o            high in the cycle the final byte is accepted
module uart_bus_bridge_txser (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  cnt_i,
  input  logic [31:0] word_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic       valid_q, valid_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_o  = 1'b0;
    if (start_i) begin
      valid_d = 1'b1;
      idx_d   = 2'd0;
      last_d  = cnt_i - 3'd1;
    end else if (valid_q && tx_ready_i) begin
      if ({1'b0, idx_q} == last_q) begin
        valid_d = 1'b0;
        idx_d   = 2'd0;
        done_o  = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      idx_q   <= 2'd0;
      last_q  <= 3'd0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    tx_data_o = word_i[7:0];
      2'd1:    tx_data_o = word_i[15:8];
      2'd2:    tx_data_o = word_i[23:16];
      default: tx_data_o = word_i[31:24];
    endcase
  end

  assign tx_valid_o = valid_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
// Parses command frames from the UART receiver, runs single-word bus reads
// and writes, and returns response bytes toward the UART transmitter.
// Frames: 0x01 addr[4] data[4] -> 0xAA ; 0x02 addr[4] -> data[4] LSB first ;
//         0x03 -> 0x55 ; anything else -> 0xEE. Multi-byte fields little-endian.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rx_data_i, rx_valid_i          received byte + one-cycle strobe
//   tx_data_o, tx_valid_o, tx_ready_i   response byte handshake
//   bus_addr_o, bus_data_o         transaction address / write data
//   bus_write_o, bus_read_o        requests, held until bus_ack_i
//   bus_data_i, bus_ack_i          read data + one-cycle completion
//   overrun_o                      pulse: a byte arrived in BUS/RESP and was dropped
// Parameters: ADDR_W (bus address width, 1..32), TIMEOUT_p (inter-byte timeout).
// Build option: define UART_BUS_BRIDGE_TIMEOUT_EN to abandon partial frames
// after TIMEOUT_p idle cycles in ADDR/DATA; otherwise they wait indefinitely.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT_p = 100000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_data_o,
  output logic              bus_write_o,
  output logic              bus_read_o,
  input  logic [31:0]       bus_data_i,
  input  logic              bus_ack_i,
  output logic              overrun_o
);

  if (ADDR_W < 1 || ADDR_W > 32 || TIMEOUT_p < 1) begin : g_param_check
    $error("uart_bus_bridge: ADDR_W must be 1..32 and TIMEOUT_p >= 1");
  end

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        overrun_q, overrun_d;

  logic        tx_start;
  logic [2:0]  tx_len;
  logic        tx_done;
  logic        tmo_fire;

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_p + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle cycles while a frame is partially received; any byte, or
  // any other state, holds it at zero.
  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if ((state_q == ST_ADDR || state_q == ST_DATA) && !rx_valid_i) begin
      if (tmo_q == TMO_W'(TIMEOUT_p - 1)) begin
        tmo_fire = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    tx_start = 1'b0;
    tx_len   = 3'd1;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) begin
          case (rx_data_i)
            CMD_WRITE: begin
              wr_d    = 1'b1;
              state_d = ST_ADDR;
            end
            CMD_READ: begin
              wr_d    = 1'b0;
              state_d = ST_ADDR;
            end
            CMD_PING: begin
              data_d   = {24'd0, RSP_PONG};
              tx_start = 1'b1;
              state_d  = ST_RESP;
            end
            default: begin
              data_d   = {24'd0, RSP_ERR};
              tx_start = 1'b1;
              state_d  = ST_RESP;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (rx_valid_i) begin
          // Bytes enter at the top so the first (least significant) byte
          // ends up in [7:0] after four shifts.
          addr_d = {rx_data_i, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = wr_q ? ST_DATA : ST_BUS;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid_i) begin
          data_d = {rx_data_i, data_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack_i) begin
          // The data register doubles as the response word.
          tx_start = 1'b1;
          if (wr_q) begin
            data_d = {24'd0, RSP_ACK};
            tx_len = 3'd1;
          end else begin
            data_d = bus_data_i;
            tx_len = 3'd4;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_fire) begin
      state_d = ST_IDLE;
    end
    if (state_d != state_q) begin
      cnt_d = 2'd0;
    end
  end

  assign overrun_d = rx_valid_i && (state_q == ST_BUS || state_q == ST_RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      wr_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      overrun_q <= overrun_d;
    end
  end

  // Requests decode straight from the state flop so reset drops them at once.
  assign bus_write_o = (state_q == ST_BUS) &&  wr_q;
  assign bus_read_o  = (state_q == ST_BUS) && !wr_q;
  assign bus_addr_o  = addr_q[ADDR_W-1:0];
  assign bus_data_o  = data_q;
  assign overrun_o   = overrun_q;

  uart_bus_bridge_txser u_txser (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (tx_start),
    .cnt_i      (tx_len),
    .word_i     (data_q),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (tx_done)
  );

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Host-side command bridge on the far end of the UART byte stream. It parses command frames arriving from the UART receiver, runs single-word read and write transactions on the internal memory bus, and emits response bytes back toward the UART transmitter. It sits between the UART byte ports (RX byte pulse in, TX byte handshake out) and a bus-master port. It serves as the debug and loader path into the SoC.

## Interface
- ADDR_W, 32, width of the bus address.
- TIMEOUT_p, 100000, inter-byte timeout in clk_i cycles. Used only when the timeout feature is compiled in.
- clk_i  in  1  system clock, all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle pulse; rx_data_i is valid in that cycle.
- tx_data_o  out  8  response byte.
- tx_valid_o  out  1  tx_data_o is valid.
- tx_ready_i  in  1  the TX side accepts a byte when tx_valid_o and tx_ready_i are both high.
- bus_addr_o  out  ADDR_W  transaction address.
- bus_data_o  out  32  write data.
- bus_write_o  out  1  write request, held until ack.
- bus_read_o  out  1  read request, held until ack.
- bus_data_i  in  32  read data, valid with bus_ack_i.
- bus_ack_i  in  1  one-cycle transaction completion.
- overrun_o  out  1  one-cycle pulse when a byte is dropped.

## Operation
- Frame format:
  - Command byte first.
  - 0x01 WRITE: 4 address bytes, then 4 data bytes.
  - 0x02 READ: 4 address bytes.
  - 0x03 PING: no payload.
- All multi-byte fields are little-endian. Address bytes beyond ADDR_W are received and discarded.
- Responses:
  - WRITE returns 0xAA.
  - READ returns 4 data bytes, LSB first.
  - PING returns 0x55.
  - Any other command byte returns 0xEE, then the FSM returns to IDLE.
- FSM states:
  - IDLE: wait for a command byte.
  - ADDR: collect 4 address bytes.
  - DATA: collect 4 data bytes (WRITE only).
  - BUS: request asserted, waiting for ack.
  - RESP: emitting response bytes.
- Transitions:
  - IDLE to ADDR on 0x01 or 0x02.
  - IDLE to RESP on 0x03 or an unknown command.
  - ADDR to DATA (WRITE) or to BUS (READ) after the 4th address byte.
  - DATA to BUS after the 4th data byte.
  - BUS to RESP on bus_ack_i.
  - RESP to IDLE once the last response byte is accepted.
- Byte counter: 2 bits, cleared on every state entry.
- Shift registers:
  - Address is a 32-bit shift register; bytes shift in at the top, and bus_addr_o takes the low ADDR_W bits.
  - Write data uses a 32-bit register filled the same way.
  - The read response reuses the data register, loaded from bus_data_i on ack.
- Dropped bytes: an rx_valid_i pulse in BUS or RESP is dropped and pulses overrun_o in the following cycle. The FSM is unaffected.
- Reset values:
  - FSM is in IDLE.
  - Address, data and counter are 0.
  - tx_valid_o, bus_write_o, bus_read_o and overrun_o are 0.
  - tx_data_o and bus_addr_o are 0.

## Timing
- rx bytes are registered on the cycle rx_valid_i is high. There is no backpressure on RX.
- bus_read_o / bus_write_o go high the cycle after the final frame byte is captured. They stay high, with address and data stable, until the cycle bus_ack_i is sampled high, then drop the next cycle.
- bus_ack_i without an outstanding request is ignored.
- First response byte:
  - READ/WRITE: tx_valid_o rises the cycle after ack.
  - PING/error: tx_valid_o rises the cycle after the command byte.
- tx_data_o is stable while tx_valid_o is high and tx_ready_i is low.
- After each accepted byte, the next byte is presented in the following cycle with tx_valid_o held high.
- After the final accepted byte, tx_valid_o drops.
- Asserting rst_ni low mid-frame or mid-transaction immediately clears requests and tx_valid_o. A pending bus ack after reset is ignored.

## Configuration
- UART_BUS_BRIDGE_TIMEOUT_EN defined:
  - A counter runs in ADDR and DATA and reloads on every rx_valid_i.
  - When TIMEOUT_p cycles elapse with no byte, the FSM returns to IDLE, discards the partial frame and sends no response.
  - BUS and RESP are never timed out.
- Undefined: there is no counter, and partial frames wait indefinitely.

## Structure
- Shared package uart_bus_bridge_pkg holds:
  - command codes CMD_WRITE=0x01, CMD_READ=0x02, CMD_PING=0x03;
  - response codes RSP_ACK=0xAA, RSP_PONG=0x55, RSP_ERR=0xEE;
  - the FSM state enum.
- One natural sub-module: uart_bus_bridge_txser. It takes a 1–4 byte response (count plus 32-bit word), owns tx_valid_o and the byte index, and signals done.
- Parser, registers and bus control stay in the top.

## Test plan
- PING: rx 0x03, tx_ready_i=1 → tx 0x55 exactly once. No bus activity.
- WRITE: rx 01 10 00 00 00 EF BE AD DE → one bus_write_o with addr 0x00000010 and data 0xDEADBEEF. Hold ack off 5 cycles, then pulse it → tx 0xAA.
- READ with stalls: rx 02 04 00 00 00, ack with bus_data_i=0x12345678, tx_ready_i toggling → tx bytes 78 56 34 12 in order, each stable while stalled.
- Unknown command 0x7F → tx 0xEE, back to IDLE. A following PING still answers 0x55.
- Byte arriving in BUS or RESP → overrun_o pulses once. The response is unchanged.
- With TIMEOUT_EN: rx 02 04, then silence for TIMEOUT_p+1 cycles → IDLE, no bus request. Next rx 03 → 0x55. Also pull rst_ni low during BUS → requests drop with no clock edge.
